// File: rtl/cache_ctrl_2way.sv
// Sequencing controller for a 2-way set-associative, word-per-line, write-through cache.
// Owns valid/LRU state and hit/miss statistics; tag and data storage live in external way BRAMs.
module cache_ctrl_2way #(
    parameter int TAG_WIDTH  = 13,
    parameter int DATA_WIDTH = 16,
    parameter int SET_WIDTH  = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            cpu_req_valid,
    output logic                            cpu_req_ready,
    input  logic                            cpu_req_we,
    input  logic [TAG_WIDTH+SET_WIDTH-1:0]  cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]           cpu_req_wdata,
    output logic                            cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]           cpu_resp_rdata,
    input  logic                            flush,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_we,
    output logic [TAG_WIDTH+SET_WIDTH-1:0]  mem_req_addr,
    output logic [DATA_WIDTH-1:0]           mem_req_wdata,
    input  logic                            mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]           mem_resp_rdata,
    output logic [1:0]                      way_enable_read,
    output logic [1:0]                      way_we_tag,
    output logic [1:0]                      way_we_data,
    output logic [SET_WIDTH-1:0]            way_set_index,
    output logic [TAG_WIDTH-1:0]            way_tag_in,
    output logic [DATA_WIDTH-1:0]           way_data_in,
    input  logic [TAG_WIDTH-1:0]            way0_tag_out,
    input  logic [TAG_WIDTH-1:0]            way1_tag_out,
    input  logic [DATA_WIDTH-1:0]           way0_data_out,
    input  logic [DATA_WIDTH-1:0]           way1_data_out,
    output logic [CNT_WIDTH-1:0]            hit_cnt,
    output logic [CNT_WIDTH-1:0]            miss_cnt
);

    localparam int NUM_SETS = 1 << SET_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        MEM_REQ,
        MEM_WAIT,
        FILL
    } state_t;

    state_t                 state;
    logic                   req_we;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [SET_WIDTH-1:0]   req_set;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic [DATA_WIDTH-1:0]  fill_data;
    logic [NUM_SETS-1:0]    valid0;
    logic [NUM_SETS-1:0]    valid1;
    logic [NUM_SETS-1:0]    lru;

    logic [1:0]             hit;
    logic                   victim;
    logic [1:0]             victim_mask;

    assign hit[0] = valid0[req_set] && (way0_tag_out == req_tag);
    assign hit[1] = valid1[req_set] && (way1_tag_out == req_tag);

    // lru[set] names the way to evict next; empty ways are always filled first
    assign victim      = !valid0[req_set] ? 1'b0 :
                         !valid1[req_set] ? 1'b1 : lru[req_set];
    assign victim_mask = victim ? 2'b10 : 2'b01;

    assign cpu_req_ready   = resetn && !flush && (state == IDLE);
    assign way_enable_read = (state == LOOKUP) ? 2'b11 : 2'b00;
    assign way_we_tag      = (state == FILL) ? victim_mask : 2'b00;
    assign way_we_data     = (state == FILL)               ? victim_mask :
                             (state == COMPARE && req_we)  ? hit         : 2'b00;
    assign way_set_index   = req_set;
    assign way_tag_in      = req_tag;
    assign way_data_in     = (state == FILL) ? fill_data : req_wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            req_we         <= 1'b0;
            req_tag        <= '0;
            req_set        <= '0;
            req_wdata      <= '0;
            fill_data      <= '0;
            valid0         <= '0;
            valid1         <= '0;
            lru            <= '0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid0 <= '0;
                        valid1 <= '0;
                    end else if (cpu_req_valid) begin
                        req_we    <= cpu_req_we;
                        {req_tag, req_set} <= cpu_req_addr;
                        req_wdata <= cpu_req_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: state <= COMPARE;
                COMPARE: begin
                    if (hit != 2'b00) begin
                        lru[req_set] <= ~hit[1];
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
                    end else if (miss_cnt != '1) begin
                        miss_cnt <= miss_cnt + CNT_WIDTH'(1);
                    end
                    // Only a read hit completes locally; everything else goes to memory
                    if (hit != 2'b00 && !req_we) begin
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_rdata <= hit[1] ? way1_data_out : way0_data_out;
                        state          <= IDLE;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= req_we;
                        mem_req_addr  <= {req_tag, req_set};
                        mem_req_wdata <= req_we ? req_wdata : '0;
                        state         <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= '0;
                        mem_req_wdata <= '0;
                        if (req_we) begin
                            cpu_resp_valid <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        fill_data <= mem_resp_rdata;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (victim) valid1[req_set] <= 1'b1;
                    else        valid0[req_set] <= 1'b1;
                    lru[req_set]   <= ~victim;
                    cpu_resp_valid <= 1'b1;
                    cpu_resp_rdata <= fill_data;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed bench for cache_ctrl_2way with behavioural way BRAMs, a backing-memory responder
// and a response scoreboard fed at request time and drained when cpu_resp_valid pulses.
module tb_cache_ctrl_2way;

    logic        clk;
    logic        resetn;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [20:0] cpu_req_addr;
    logic [15:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [15:0] cpu_resp_rdata;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [20:0] mem_req_addr;
    logic [15:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [15:0] mem_resp_rdata;
    logic [1:0]  way_enable_read;
    logic [1:0]  way_we_tag;
    logic [1:0]  way_we_data;
    logic [7:0]  way_set_index;
    logic [12:0] way_tag_in;
    logic [15:0] way_data_in;
    logic [12:0] way0_tag_out;
    logic [12:0] way1_tag_out;
    logic [15:0] way0_data_out;
    logic [15:0] way1_data_out;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [15:0] exp_q[$];
    logic [15:0] backing [logic [20:0]];

    logic [12:0] tag_mem0 [256];
    logic [12:0] tag_mem1 [256];
    logic [15:0] data_mem0 [256];
    logic [15:0] data_mem1 [256];

    cache_ctrl_2way dut (
        .clk             (clk),
        .resetn          (resetn),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_ready   (cpu_req_ready),
        .cpu_req_we      (cpu_req_we),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_wdata   (cpu_req_wdata),
        .cpu_resp_valid  (cpu_resp_valid),
        .cpu_resp_rdata  (cpu_resp_rdata),
        .flush           (flush),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_we      (mem_req_we),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata),
        .way_enable_read (way_enable_read),
        .way_we_tag      (way_we_tag),
        .way_we_data     (way_we_data),
        .way_set_index   (way_set_index),
        .way_tag_in      (way_tag_in),
        .way_data_in     (way_data_in),
        .way0_tag_out    (way0_tag_out),
        .way1_tag_out    (way1_tag_out),
        .way0_data_out   (way0_data_out),
        .way1_data_out   (way1_data_out),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Two way BRAMs: 1-cycle synchronous read, write on the clock edge
    initial begin
        for (int s = 0; s < 256; s++) begin
            tag_mem0[s] = '0; tag_mem1[s] = '0;
            data_mem0[s] = '0; data_mem1[s] = '0;
        end
        way0_tag_out = '0; way1_tag_out = '0;
        way0_data_out = '0; way1_data_out = '0;
        forever begin
            @(posedge clk);
            if (way_enable_read[0]) begin
                way0_tag_out  = tag_mem0[way_set_index];
                way0_data_out = data_mem0[way_set_index];
            end
            if (way_enable_read[1]) begin
                way1_tag_out  = tag_mem1[way_set_index];
                way1_data_out = data_mem1[way_set_index];
            end
            if (way_we_tag[0])  tag_mem0[way_set_index]  = way_tag_in;
            if (way_we_tag[1])  tag_mem1[way_set_index]  = way_tag_in;
            if (way_we_data[0]) data_mem0[way_set_index] = way_data_in;
            if (way_we_data[1]) data_mem1[way_set_index] = way_data_in;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] mem_value(input logic [20:0] a);
        if (backing.exists(a)) return backing[a];
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Scoreboard drain
    always @(negedge clk) begin
        if (resetn && cpu_resp_valid) begin
            checkOutput("resp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) checkOutput("resp_rdata", 32'(cpu_resp_rdata), 32'(exp_q.pop_front()));
        end
    end

    // One CPU access, acting as backing memory, with latency and way-write checks
    task automatic applyStimulus(input logic we, input logic [20:0] addr, input logic [15:0] wdata,
                                 input bit exp_hit, input int ready_delay, input int resp_delay,
                                 input logic [1:0] exp_tag_ways, input logic [1:0] exp_data_ways);
        int k = 0;
        int req_cycles = 0;
        int wait_cnt = 0;
        int ready_k = -100;
        int drive_k = -100;
        int resp_k = -100;
        bit mem_seen = 0;
        bit waiting = 0;
        bit done = 0;
        logic [1:0] tag_seen = 2'b00;
        logic [1:0] data_seen = 2'b00;
        logic [15:0] exp_data;

        exp_data = we ? 16'h0000 : mem_value(addr);
        if (we) backing[addr] = wdata;
        if (exp_hit) exp_hits++; else exp_misses++;
        exp_q.push_back(exp_data);

        checkOutput("req_ready", 32'(cpu_req_ready), 32'd1);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        @(posedge clk);
        while (!done && k < 60) begin
            @(negedge clk);
            cpu_req_valid  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            tag_seen  |= way_we_tag;
            data_seen |= way_we_data;
            if (cpu_resp_valid) begin
                done   = 1;
                resp_k = k;
            end else begin
                if (mem_req_valid) begin
                    mem_seen = 1;
                    checkOutput("mem_addr", 32'(mem_req_addr), 32'(addr));
                    checkOutput("mem_we", 32'(mem_req_we), 32'(we));
                    if (we) checkOutput("mem_wdata", 32'(mem_req_wdata), 32'(wdata));
                    if (req_cycles >= ready_delay) begin
                        mem_req_ready = 1'b1;
                        ready_k = k;
                        if (!we) begin
                            waiting  = 1;
                            wait_cnt = 0;
                        end
                    end
                    req_cycles++;
                end else if (waiting) begin
                    if (wait_cnt == resp_delay) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_rdata = exp_data;
                        drive_k = k;
                        waiting = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
                @(posedge clk);
                k++;
            end
        end

        checkOutput("resp_seen", 32'(done), 32'd1);
        checkOutput("mem_used", 32'(mem_seen), 32'(we || !exp_hit));
        if (done) begin
            if (!we && exp_hit)  checkOutput("hit_latency", 32'(resp_k), 32'd2);
            else if (!we)        checkOutput("miss_latency", 32'(resp_k), 32'(drive_k + 2));
            else                 checkOutput("write_latency", 32'(resp_k), 32'(ready_k + 1));
        end
        checkOutput("way_we_tag", 32'(tag_seen), 32'(exp_tag_ways));
        checkOutput("way_we_data", 32'(data_seen), 32'(exp_data_ways));
        checkOutput("hit_cnt", hit_cnt, 32'(exp_hits));
        checkOutput("miss_cnt", miss_cnt, 32'(exp_misses));
    endtask

    initial begin
        bit resp_seen;
        resetn = 1'b0; flush = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        backing[21'h00005] = 16'hBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(cpu_req_ready), 32'd0);
        checkOutput("rst_hit_cnt", hit_cnt, 32'd0);
        checkOutput("rst_miss_cnt", miss_cnt, 32'd0);
        checkOutput("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_way_en", 32'(way_enable_read), 32'd0);
        resetn = 1'b1;
        #1 checkOutput("idle_ready", 32'(cpu_req_ready), 32'd1);

        $display("[TB] read miss / hit on set 0x05");
        applyStimulus(1'b0, 21'h00005, 16'h0, 1'b0, 0, 3, 2'b01, 2'b01);
        applyStimulus(1'b0, 21'h00005, 16'h0, 1'b1, 0, 0, 2'b00, 2'b00);

        $display("[TB] conflict fills and LRU eviction");
        applyStimulus(1'b0, 21'h00105, 16'h0, 1'b0, 1, 0, 2'b10, 2'b10);
        applyStimulus(1'b0, 21'h00205, 16'h0, 1'b0, 0, 2, 2'b01, 2'b01);
        applyStimulus(1'b0, 21'h00105, 16'h0, 1'b1, 0, 0, 2'b00, 2'b00);
        applyStimulus(1'b0, 21'h00005, 16'h0, 1'b0, 2, 1, 2'b01, 2'b01);

        $display("[TB] write hit with stalled memory, then write miss");
        applyStimulus(1'b1, 21'h00105, 16'h1234, 1'b1, 4, 0, 2'b00, 2'b10);
        applyStimulus(1'b0, 21'h00105, 16'h0, 1'b1, 0, 0, 2'b00, 2'b00);
        applyStimulus(1'b1, 21'h1FF00, 16'h7777, 1'b0, 0, 0, 2'b00, 2'b00);
        applyStimulus(1'b0, 21'h1FF00, 16'h0, 1'b0, 0, 0, 2'b01, 2'b01);

        $display("[TB] flush");
        flush = 1'b1;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 21'h1FF00;
        #1 checkOutput("flush_blocks_ready", 32'(cpu_req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        cpu_req_valid = 1'b0;
        #1 checkOutput("flush_not_accepted", 32'(cpu_req_ready), 32'd1);
        applyStimulus(1'b0, 21'h00005, 16'h0, 1'b0, 0, 1, 2'b01, 2'b01);

        $display("[TB] reset during memory wait");
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 21'h00105;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_req_valid; i++) @(negedge clk);
        checkOutput("abandon_mem_req", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready", 32'(cpu_req_ready), 32'd0);
        checkOutput("midrst_hit_cnt", hit_cnt, 32'd0);
        checkOutput("midrst_miss_cnt", miss_cnt, 32'd0);
        resetn = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 16'hDEAD;
        resp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            resp_seen |= cpu_resp_valid;
        end
        checkOutput("late_resp_ignored", 32'(resp_seen), 32'd0);
        exp_hits = 0;
        exp_misses = 0;
        applyStimulus(1'b0, 21'h00005, 16'h0, 1'b0, 0, 0, 2'b01, 2'b01);
        applyStimulus(1'b0, 21'h00005, 16'h0, 1'b1, 0, 0, 2'b00, 2'b00);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Sequencing controller for a 2-way set-associative, word-per-line cache built from two cache_way instances (tag BRAM + data BRAM per way, 1-cycle synchronous read).
- Accepts single-word CPU read/write requests, does tag lookup, returns hits, and fetches misses from a backing memory port.
- Owns the valid bits, per-set LRU bits and hit/miss counters.
- Writes are write-through, no-write-allocate.

Parameters:
- TAG_WIDTH, 13, tag width; address = {tag, set}.
- DATA_WIDTH, 16, word width.
- SET_WIDTH, 8, set index width; 2^SET_WIDTH sets.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- cpu_req_valid  in  1  request valid.
- cpu_req_ready  out  1  controller can accept.
- cpu_req_we  in  1  1=write, 0=read.
- cpu_req_addr  in  TAG_WIDTH+SET_WIDTH  word address.
- cpu_req_wdata  in  DATA_WIDTH  write data.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_rdata  out  DATA_WIDTH  read data (0 for writes).
- flush  in  1  invalidate all lines (IDLE only).
- mem_req_valid  out  1  backing-memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  memory write.
- mem_req_addr  out  TAG_WIDTH+SET_WIDTH  memory address.
- mem_req_wdata  out  DATA_WIDTH  memory write data.
- mem_resp_valid  in  1  read data valid.
- mem_resp_rdata  in  DATA_WIDTH  read data.
- way_enable_read  out  2  per-way BRAM read enable.
- way_we_tag  out  2  per-way tag write enable.
- way_we_data  out  2  per-way data write enable.
- way_set_index  out  SET_WIDTH  shared set index.
- way_tag_in  out  TAG_WIDTH  shared tag write value.
- way_data_in  out  DATA_WIDTH  shared data write value.
- way0_tag_out, way1_tag_out  in  TAG_WIDTH  tag read.
- way0_data_out, way1_data_out  in  DATA_WIDTH  data read.
- hit_cnt, miss_cnt  out  CNT_WIDTH  statistics.

Behaviour:
- Reset (resetn=0 at clk edge):
  - State=IDLE; all valid bits and LRU bits 0; counters 0.
  - All outputs 0; cpu_req_ready=0 while resetn=0.
  - Reset mid-operation abandons the transaction with no response; a later mem_resp_valid is ignored.
- States:
  - IDLE: cpu_req_ready=1.
    - flush=1 clears all valid bits at the edge; the request is not accepted that cycle (ready=0 when flush=1).
    - Otherwise, on valid&&ready: latch we/addr/wdata; -> LOOKUP.
  - LOOKUP: way_enable_read=2'b11, way_set_index=latched set; -> COMPARE.
  - COMPARE: hit[i] = valid[i][set] && wayi_tag_out==tag (at most one).
    - Read hit: at edge, resp_valid=1, rdata=hit data, LRU[set]=~hit way, hit_cnt++; -> IDLE.
    - Read miss: miss_cnt++; -> MEM_REQ.
    - Write hit: way_we_data[hit]=1 with wdata, LRU update, hit_cnt++; -> MEM_REQ.
    - Write miss: miss_cnt++; -> MEM_REQ; no allocation.
  - MEM_REQ: mem_req_valid=1 with mem_req_we/addr/wdata held stable until mem_req_ready.
    - Read: -> MEM_WAIT.
    - Write: resp_valid=1, rdata=0; -> IDLE.
  - MEM_WAIT: on mem_resp_valid, capture rdata; -> FILL. mem_resp_valid is ignored in all other states.
  - FILL: select victim = first invalid way (way0 preferred), else LRU[set].
    - Assert way_we_tag and way_we_data on the victim with the latched tag and captured data.
    - Set the victim's valid bit; LRU[set]=~victim.
    - resp_valid=1, rdata=fill data; -> IDLE.
- Latency (accepting edge = E0):
  - Read hit: response after E2.
  - Miss: response 1 cycle after the mem_resp_valid edge.
  - Write: response on the mem_req_ready edge.
- Counters saturate at all-ones; not cleared by flush.
- way_enable_read and way_we_* are 0 outside the states listed above.
- Requests never overlap; the next one can be accepted in the cycle resp_valid is high.

Test Plan:
- Reset, then read 0x00005 with memory returning 0xBEEF after 3 cycles -> mem_req addr 0x00005, we=0; resp rdata=0xBEEF; way0 filled; miss_cnt=1.
- Repeat read 0x00005 -> no mem_req; resp_valid exactly 2 edges after acceptance with 0xBEEF; hit_cnt=1.
- Read 0x00105 then 0x00205 (same set 0x05, different tags) -> 0x00105 fills way1; 0x00205 evicts LRU way0. A later read of 0x00005 misses; a read of 0x00105 hits.
- Write 0x1234 to cached 0x00105 -> way_we_data on the hit way, mem write addr 0x00105 data 0x1234 held through 4 cycles of mem_req_ready=0. A subsequent read returns 0x1234 as a hit.
- Write miss to 0x1FF00 -> mem write only, no tag/data write; a following read of 0x1FF00 misses.
- Flush, then read 0x00005 -> miss. Also: assert resetn=0 during MEM_WAIT, then a late mem_resp_valid -> no resp_valid, all valid bits 0.
